// File: rtl/uxn_mem_arbiter.sv
// Single-port memory arbiter/sequencer for the uxn 64 KiB main memory.
// Shares the port between fetch (0), data (1) and device (2); byte or big-endian short accesses.
module uxn_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [2:0]  short,
  input  logic [47:0] addr,
  input  logic [47:0] wdata,
  output logic [2:0]  ack,
  output logic [15:0] rdata,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  state_t      state_r;
  logic        lat_we_r;
  logic        lat_short_r;
  logic [15:0] lat_addr_r;
  logic [15:0] lat_wdata_r;
  logic [1:0]  grant_r;
  logic [7:0]  starve_cnt_r;
  logic [7:0]  hi_r;
  logic [2:0]  ack_r;
  logic        busy_r;
  logic [15:0] mem_addr_r;
  logic        mem_we_r;
  logic [7:0]  mem_wdata_r;

  logic        arb_cycle_s;
  logic [2:0]  mask_s;
  logic [2:0]  elig_s;
  logic        win_valid_s;
  logic [1:0]  win_s;
  logic        win_we_s;
  logic        win_short_s;
  logic [15:0] win_addr_s;
  logic [15:0] win_wdata_s;

  // Arbitration: data > fetch > device, device forced once it has starved long enough.
  always_comb begin
    arb_cycle_s = (state_r == IDLE) || (state_r == FIN);
    mask_s      = 3'b000;
    if (state_r == FIN) begin
      mask_s = 3'b001 << grant_r;
    end else begin
      mask_s = 3'b000;
    end
    elig_s      = arb_cycle_s ? (req & ~mask_s) : 3'b000;
    win_valid_s = |elig_s;
    if (elig_s[2] && (starve_cnt_r >= LIMIT_C)) begin
      win_s = 2'd2;
    end else if (elig_s[1]) begin
      win_s = 2'd1;
    end else if (elig_s[0]) begin
      win_s = 2'd0;
    end else if (elig_s[2]) begin
      win_s = 2'd2;
    end else begin
      win_s = 2'd3;
    end
    case (win_s)
      2'd0: begin
        win_we_s = we[0]; win_short_s = short[0];
        win_addr_s = addr[15:0]; win_wdata_s = wdata[15:0];
      end
      2'd1: begin
        win_we_s = we[1]; win_short_s = short[1];
        win_addr_s = addr[31:16]; win_wdata_s = wdata[31:16];
      end
      2'd2: begin
        win_we_s = we[2]; win_short_s = short[2];
        win_addr_s = addr[47:32]; win_wdata_s = wdata[47:32];
      end
      default: begin
        win_we_s = 1'b0; win_short_s = 1'b0;
        win_addr_s = 16'h0000; win_wdata_s = 16'h0000;
      end
    endcase
  end

  // Sequencer FSM with registered memory-port and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      lat_we_r     <= 1'b0;
      lat_short_r  <= 1'b0;
      lat_addr_r   <= 16'h0000;
      lat_wdata_r  <= 16'h0000;
      grant_r      <= 2'b11;
      starve_cnt_r <= 8'h00;
      hi_r         <= 8'h00;
      ack_r        <= 3'b000;
      busy_r       <= 1'b0;
      mem_addr_r   <= 16'h0000;
      mem_we_r     <= 1'b0;
      mem_wdata_r  <= 8'h00;
    end else begin
      ack_r <= 3'b000;

      if (!req[2]) begin
        starve_cnt_r <= 8'h00;
      end else if (win_valid_s) begin
        if (win_s == 2'd2) begin
          starve_cnt_r <= 8'h00;
        end else if (starve_cnt_r != 8'hFF) begin
          starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
          starve_cnt_r <= starve_cnt_r;
        end
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      if (win_valid_s) begin
        state_r     <= B0;
        busy_r      <= 1'b1;
        grant_r     <= win_s;
        lat_we_r    <= win_we_s;
        lat_short_r <= win_short_s;
        lat_addr_r  <= win_addr_s;
        lat_wdata_r <= win_wdata_s;
        mem_addr_r  <= win_addr_s;
        mem_we_r    <= win_we_s;
        mem_wdata_r <= win_short_s ? win_wdata_s[15:8] : win_wdata_s[7:0];
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            grant_r <= 2'b11;
          end
          B0: begin
            if (lat_short_r) begin
              state_r     <= B1;
              mem_addr_r  <= lat_addr_r + 16'd1;
              mem_we_r    <= lat_we_r;
              mem_wdata_r <= lat_wdata_r[7:0];
            end else begin
              state_r     <= FIN;
              ack_r       <= 3'b001 << grant_r;
              mem_addr_r  <= 16'h0000;
              mem_we_r    <= 1'b0;
              mem_wdata_r <= 8'h00;
            end
          end
          B1: begin
            if (!lat_we_r) begin
              hi_r <= mem_rdata;
            end else begin
              hi_r <= hi_r;
            end
            state_r     <= FIN;
            ack_r       <= 3'b001 << grant_r;
            mem_addr_r  <= 16'h0000;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
          end
          FIN: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            grant_r <= 2'b11;
          end
          default: begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            grant_r     <= 2'b11;
            mem_addr_r  <= 16'h0000;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
          end
        endcase
      end
    end
  end

  // Synchronous memory returns data in FIN, so the response is formed from mem_rdata directly.
  always_comb begin
    if ((state_r == FIN) && !lat_we_r) begin
      rdata = lat_short_r ? {hi_r, mem_rdata} : {8'h00, mem_rdata};
    end else begin
      rdata = 16'h0000;
    end
  end

  assign ack       = ack_r;
  assign grant_id  = grant_r;
  assign busy      = busy_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_uxn_mem_arbiter.sv
// Directed self-checking bench for uxn_mem_arbiter with a behavioural synchronous byte memory.
module tb_uxn_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  short;
  logic [15:0] addr_v [3];
  logic [15:0] wdata_v [3];
  logic [47:0] addr;
  logic [47:0] wdata;
  logic [2:0]  ack;
  logic [15:0] rdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  int          wr_cnt = 0;
  int          wr_base;
  logic [2:0]  prev_ack;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  assign addr  = {addr_v[2], addr_v[1], addr_v[0]};
  assign wdata = {wdata_v[2], wdata_v[1], wdata_v[0]};

  uxn_mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .short(short),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata),
    .grant_id(grant_id), .busy(busy), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous read-before-write memory with a bench preload path.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // One cycle; requesters drop req the cycle after their ack.
  task automatic tick();
    @(posedge clk); #1;
    req = req & ~prev_ack;
    prev_ack = ack;
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; we = 3'b000; short = 3'b000;
    pre_en = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00; prev_ack = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 16'h0000; wdata_v[i] = 16'h0000;
    end
    poke(16'h1234, 8'hAB);
    poke(16'h2000, 8'h12);
    poke(16'h2001, 8'h34);
    poke(16'h0010, 8'h11);
    poke(16'h0020, 8'h22);
    poke(16'h0030, 8'h33);
    poke(16'h4000, 8'h00);
    poke(16'h4001, 8'h00);
    check("rst_ack", ack, 16'h0000);
    check("rst_grant", grant_id, 16'h0003);
    check("rst_busy", busy, 16'h0000);
    check("rst_mem_we", mem_we, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    rst = 1'b0;
    tick();

    // Single byte read by data port
    addr_v[1] = 16'h1234; req = 3'b010;
    tick();
    check("br_grant_c1", grant_id, 16'h0001);
    check("br_addr_c1", mem_addr, 16'h1234);
    check("br_ack_c1", ack, 16'h0000);
    tick();
    check("br_ack_c2", ack, 16'h0002);
    check("br_rdata", rdata, 16'h00AB);
    check("br_grant_c2", grant_id, 16'h0001);
    tick();
    check("br_idle_busy", busy, 16'h0000);
    check("br_idle_grant", grant_id, 16'h0003);

    // Short write across the top of memory
    we = 3'b001; short = 3'b001; addr_v[0] = 16'hFFFF; wdata_v[0] = 16'hBEEF;
    wr_base = wr_cnt; req = 3'b001;
    tick();
    check("sw_we_c1", mem_we, 16'h0001);
    check("sw_addr_c1", mem_addr, 16'hFFFF);
    check("sw_wd_c1", mem_wdata, 16'h00BE);
    tick();
    check("sw_we_c2", mem_we, 16'h0001);
    check("sw_addr_c2", mem_addr, 16'h0000);
    check("sw_wd_c2", mem_wdata, 16'h00EF);
    tick();
    check("sw_ack_c3", ack, 16'h0001);
    check("sw_we_c3", mem_we, 16'h0000);
    check("sw_rdata", rdata, 16'h0000);
    tick();
    check("sw_wr_count", 16'(wr_cnt - wr_base), 16'h0002);
    check("sw_mem_ffff", {8'h00, mem[16'hFFFF]}, 16'h00BE);
    check("sw_mem_0000", {8'h00, mem[16'h0000]}, 16'h00EF);

    // Short read, big-endian
    we = 3'b000; short = 3'b010; addr_v[1] = 16'h2000; req = 3'b010;
    tick(); tick();
    check("sr_ack_c2", ack, 16'h0000);
    tick();
    check("sr_ack_c3", ack, 16'h0002);
    check("sr_rdata", rdata, 16'h1234);
    tick();

    // Contention, all byte reads
    short = 3'b000; addr_v[0] = 16'h0010; addr_v[1] = 16'h0020; addr_v[2] = 16'h0030;
    req = 3'b111;
    tick();
    check("ct_grant_c1", grant_id, 16'h0001);
    tick();
    check("ct_ack_c2", ack, 16'h0002);
    check("ct_rdata_c2", rdata, 16'h0022);
    tick();
    check("ct_grant_c3", grant_id, 16'h0000);
    check("ct_busy_c3", busy, 16'h0001);
    tick();
    check("ct_ack_c4", ack, 16'h0001);
    check("ct_rdata_c4", rdata, 16'h0011);
    tick();
    check("ct_grant_c5", grant_id, 16'h0002);
    tick();
    check("ct_ack_c6", ack, 16'h0004);
    check("ct_rdata_c6", rdata, 16'h0033);
    tick();
    check("ct_idle_c7", busy, 16'h0000);

    // Starvation: data and fetch keep re-requesting, device must win after 3 losses
    req = 3'b111;
    tick(); tick();
    check("sv_ack_c2", ack, 16'h0002);
    tick();
    tick();
    req[1] = 1'b1;
    check("sv_ack_c4", ack, 16'h0001);
    tick();
    tick();
    req[0] = 1'b1;
    check("sv_ack_c6", ack, 16'h0002);
    check("sv_rdata_c6", rdata, 16'h0022);
    tick();
    check("sv_grant_c7", grant_id, 16'h0002);
    tick();
    check("sv_ack_c8", ack, 16'h0004);
    check("sv_rdata_c8", rdata, 16'h0033);
    tick();
    check("sv_grant_c9", grant_id, 16'h0000);
    tick();
    check("sv_ack_c10", ack, 16'h0001);
    tick();
    check("sv_idle_c11", busy, 16'h0000);

    // Reset during B1 of a short write
    we = 3'b001; short = 3'b001; addr_v[0] = 16'h4000; wdata_v[0] = 16'hA55A; req = 3'b001;
    tick(); tick();
    check("rm_addr_b1", mem_addr, 16'h4001);
    check("rm_we_b1", mem_we, 16'h0001);
    rst = 1'b1; req = 3'b000;
    #1;
    check("rm_busy", busy, 16'h0000);
    check("rm_ack", ack, 16'h0000);
    check("rm_we", mem_we, 16'h0000);
    check("rm_grant", grant_id, 16'h0003);
    check("rm_addr", mem_addr, 16'h0000);
    tick();
    rst = 1'b0; prev_ack = 3'b000;
    check("rm_mem_hi", {8'h00, mem[16'h4000]}, 16'h00A5);
    check("rm_mem_lo", {8'h00, mem[16'h4001]}, 16'h0000);
    we = 3'b000; short = 3'b000; addr_v[1] = 16'h1234; req = 3'b010;
    tick();
    check("rm_fresh_grant", grant_id, 16'h0001);
    tick();
    check("rm_fresh_ack", ack, 16'h0002);
    check("rm_fresh_rdata", rdata, 16'h00AB);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
